// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KP_KEYS = KP_ROWS * KP_COLS;

  // Debounce state machine states.
  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } db_state_e;

  // Classification of one complete scan frame.
  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_class_e;

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debounce: accepts a key after DEBOUNCE_FRAMES identical
// single-key frames and releases it after as many frames without it.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_done,
  input  frame_class_e frame_class,
  input  logic [3:0]   frame_code,
  output logic         accept,
  output logic [3:0]   accept_code,
  output logic         held
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);

  db_state_e     state_q;
  logic [3:0]    cand_q;
  logic [CW-1:0] cnt_q;
  logic          accept_q;
  logic          held_q;

  logic          same_single;
  logic [CW-1:0] cnt_inc;

  assign same_single = (frame_class == SINGLE) && (frame_code == cand_q);
  assign cnt_inc     = cnt_q + CNT_ONE;

  // Debounce FSM, advanced once per closed frame; accept is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      accept_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      accept_q <= 1'b0;
      if (frame_done) begin
        unique case (state_q)
          IDLE: begin
            if (frame_class == SINGLE) begin
              cand_q <= frame_code;
              cnt_q  <= CNT_ONE;
              if (CNT_ONE == CNT_MAX) begin
                state_q  <= HELD;
                accept_q <= 1'b1;
                held_q   <= 1'b1;
              end else begin
                state_q <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (same_single) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                state_q  <= HELD;
                accept_q <= 1'b1;
                held_q   <= 1'b1;
              end
            end else if (frame_class == SINGLE) begin
              // a different key: restart the count on the new candidate
              cand_q <= frame_code;
              cnt_q  <= CNT_ONE;
            end else begin
              state_q <= IDLE;
            end
          end
          HELD: begin
            if (!same_single) begin
              cnt_q <= CNT_ONE;
              if (CNT_ONE == CNT_MAX) begin
                state_q <= IDLE;
                held_q  <= 1'b0;
              end else begin
                state_q <= REL_DB;
              end
            end
          end
          REL_DB: begin
            if (same_single) begin
              state_q <= HELD;
            end else begin
              cnt_q <= cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                state_q <= IDLE;
                held_q  <= 1'b0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign accept      = accept_q;
  assign accept_code = cand_q;
  assign held        = held_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row strobe drive, column sync, frame assembly and
// classification, and a single-entry valid/ack key buffer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 5000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [KP_ROWS-1:0] kp_row,
  input  logic [KP_COLS-1:0] kp_col,
  output logic [3:0]         key_code,
  output logic               key_valid,
  input  logic               key_ack,
  output logic               key_down,
  output logic               overflow
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0]        div_cnt_q;
  logic [1:0]           row_sel_q;
  logic [KP_ROWS-1:0]   kp_row_q;
  logic [KP_COLS-1:0]   col_meta_q;
  logic [KP_COLS-1:0]   col_sync_q;
  logic [KP_KEYS-1:0]   frame_q;
  logic [3:0]           key_code_q;
  logic                 key_valid_q;
  logic                 overflow_q;

  logic [KP_COLS-1:0]   col_act;
  logic                 sample_en;
  logic                 frame_done;
  logic [KP_KEYS-1:0]   frame_now;
  logic [4:0]           ones;
  logic [3:0]           frame_code;
  frame_class_e         frame_class;
  logic                 accept;
  logic [3:0]           accept_code;
  logic                 held;

  assign col_act    = ~col_sync_q;
  assign sample_en  = (div_cnt_q == DIV_LAST);
  assign frame_done = sample_en && (row_sel_q == 2'd3);

  // Row period divider and registered one-cold row strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      row_sel_q <= 2'd0;
      kp_row_q  <= 4'b1110;
    end else if (sample_en) begin
      div_cnt_q <= '0;
      row_sel_q <= row_sel_q + 2'd1;
      kp_row_q  <= ~(4'b0001 << (row_sel_q + 2'd1));
    end else begin
      div_cnt_q <= div_cnt_q + DW'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous column inputs (idle high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
    end else begin
      col_meta_q <= kp_col;
      col_sync_q <= col_meta_q;
    end
  end

  // Capture the settled columns of the current row at the end of its period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (sample_en) begin
      frame_q[{row_sel_q, 2'b00} +: KP_COLS] <= col_act;
    end
  end

  // Classify the frame including the sample being taken this cycle, so the
  // closing row does not cost an extra cycle of latency.
  always_comb begin
    frame_now = frame_q;
    frame_now[{row_sel_q, 2'b00} +: KP_COLS] = col_act;
    ones       = 5'd0;
    frame_code = 4'd0;
    for (int i = 0; i < KP_KEYS; i++) begin
      if (frame_now[i]) begin
        ones       = ones + 5'd1;
        frame_code = 4'(i);
      end
    end
    if (ones == 5'd0)      frame_class = NONE;
    else if (ones == 5'd1) frame_class = SINGLE;
    else                   frame_class = MULTI;
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_done (frame_done),
    .frame_class(frame_class),
    .frame_code (frame_code),
    .accept     (accept),
    .accept_code(accept_code),
    .held       (held)
  );

  // Single-entry key buffer; an ack in the accept cycle frees the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      if (!key_valid_q || key_ack) begin
        key_code_q  <= accept_code;
        key_valid_q <= 1'b1;
      end else begin
        overflow_q <= 1'b1;
      end
    end else if (key_ack) begin
      key_valid_q <= 1'b0;
    end
  end

  assign kp_row    = kp_row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = held;
  assign overflow  = overflow_q;

endmodule
